// File: rtl/dmem_ctrl.sv
// dmem_ctrl: memory-stage access controller for the 16-bit pipeline.
// Turns each EX/MEM load/store into a req/ready data-cache transaction,
// stalls the upstream pipeline registers until it completes, latches load
// data for MEM/WB and sequences processor halt.
// Optional feature macro: DMEM_TIMEOUT_EN -- abandons an access after
// TIMEOUT BUSY cycles without dc_ready and raises the sticky mem_err flag.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        halt_in,
  output logic        dc_req,
  output logic        dc_we,
  output logic [15:0] dc_addr,
  output logic [15:0] dc_wdata,
  input  logic [15:0] dc_rdata,
  input  logic        dc_ready,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        halted
`ifdef DMEM_TIMEOUT_EN
  ,
  output logic        mem_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  logic   start;     // IDLE accepts a load/store this cycle
  logic   complete;  // cache finished the access this cycle

  // TIMEOUT is a cycle count held in an 8-bit saturating counter.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dmem_ctrl: TIMEOUT must be in 1..255");
  end

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] cnt;
  logic       timeout_hit;
  logic       timed_out;

  // The counter reaches TIMEOUT at the end of this BUSY cycle.
  assign timeout_hit = (cnt >= 8'(TIMEOUT - 1));
`endif

  // Next-state decode; halt_in beats a same-cycle mem op, dc_ready beats timeout.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_state = state;
    start      = 1'b0;
    complete   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    timed_out  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (halt_in) begin
          next_state = HALT;
        end else if (mem_read || mem_write) begin
          next_state = BUSY;
          start      = 1'b1;
        end
      end
      BUSY: begin
        if (dc_ready) begin
          next_state = DONE;
          complete   = 1'b1;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (timeout_hit) begin
          next_state = DONE;
          timed_out  = 1'b1;
        end
`endif
      end
      DONE:    next_state = IDLE;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Stall is the only combinational output: it must hold EX/MEM in the
  // same cycle the op is first seen.
  assign stall = ((state == IDLE) && !halt_in && (mem_read || mem_write)) ||
                 (state == BUSY) || (state == HALT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Cache request flop and the operation latched when the access is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_req   <= 1'b0;
      dc_we    <= 1'b0;
      dc_addr  <= 16'h0000;
      dc_wdata <= 16'h0000;
    end else begin
      dc_req <= (next_state == BUSY);
      if (start) begin
        dc_we    <= mem_write;  // write wins when both are set
        dc_addr  <= addr;
        dc_wdata <= wdata;
      end
    end
  end

  // Load data capture; rdata holds across stores and abandoned accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= 16'h0000;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= complete && !dc_we;
      if (complete && !dc_we) rdata <= dc_rdata;
    end
  end

  // Halt indicator, decoded from the state we are entering.
  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= (next_state == HALT);
  end

`ifdef DMEM_TIMEOUT_EN
  // BUSY cycle counter: cleared on accept, saturates at 255.
  always_ff @(posedge clk) begin
    if (rst || start)                        cnt <= 8'd0;
    else if (state == BUSY && cnt != 8'hFF)  cnt <= cnt + 8'd1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)            mem_err <= 1'b0;
    else if (timed_out) mem_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized self-checking bench for dmem_ctrl. Each access
// is checked cycle by cycle against a transaction-level expectation: a
// detect cycle, waits+1 BUSY cycles (capped at TIMEOUT when the timeout
// feature is built), then one DONE cycle.
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, halt_in;
  logic [15:0] addr, wdata;
  logic        dc_req, dc_we;
  logic [15:0] dc_addr, dc_wdata;
  logic [15:0] dc_rdata;
  logic        dc_ready;
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        halted;
`ifdef DMEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: last load result and the sticky error flag.
  logic [15:0] exp_rdata;
  logic        exp_err;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr        (addr),
    .wdata       (wdata),
    .halt_in     (halt_in),
    .dc_req      (dc_req),
    .dc_we       (dc_we),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_rdata    (dc_rdata),
    .dc_ready    (dc_ready),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .halted      (halted)
`ifdef DMEM_TIMEOUT_EN
    ,
    .mem_err     (mem_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_err(input string tag);
`ifdef DMEM_TIMEOUT_EN
    check(tag, mem_err, exp_err);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    halt_in   = 1'b0;
    addr      = 16'($urandom);
    wdata     = 16'($urandom);
    dc_ready  = 1'b0;
    dc_rdata  = 16'($urandom);
  endtask

  // A cycle with no op in EX/MEM; stray dc_ready must be ignored.
  task automatic idle_cycle();
    quiet_inputs();
    dc_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_req", dc_req, 0);
    check("idle_valid", rdata_valid, 0);
    check("idle_rdata", rdata, exp_rdata);
    check("idle_halted", halted, 0);
    check_err("idle_err");
    next_cycle();
  endtask

  // One load/store from the detect cycle through DONE.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input int waits,
                        input logic [15:0] rd_val);
    bit is_read   = !wr;
    int busy_cyc  = waits + 1;
    bit timed_out = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    if (busy_cyc > TO) begin
      busy_cyc  = TO;
      timed_out = 1'b1;
    end
`endif
    // Detect cycle in IDLE.
    mem_read  = rd;
    mem_write = wr;
    halt_in   = 1'b0;
    addr      = a;
    wdata     = wd;
    dc_ready  = 1'($urandom_range(0, 1));
    dc_rdata  = 16'($urandom);
    @(negedge clk);
    check("detect_stall", stall, 1);
    check("detect_req", dc_req, 0);
    next_cycle();
    // BUSY cycles; changing addr/wdata shows the DUT uses its latched copy.
    for (int c = 1; c <= busy_cyc; c++) begin
      addr     = 16'($urandom);
      wdata    = 16'($urandom);
      dc_ready = !timed_out && (c == busy_cyc);
      dc_rdata = (c == busy_cyc) ? rd_val : 16'($urandom);
      @(negedge clk);
      check("busy_req", dc_req, 1);
      check("busy_we", dc_we, wr);
      check("busy_addr", dc_addr, a);
      check("busy_wdata", dc_wdata, wd);
      check("busy_stall", stall, 1);
      check("busy_valid", rdata_valid, 0);
      check("busy_rdata", rdata, exp_rdata);
      check_err("busy_err");
      next_cycle();
    end
    if (timed_out)    exp_err = 1'b1;
    else if (is_read) exp_rdata = rd_val;
    // DONE: the retiring op is still visible and must not restart.
    dc_ready = 1'($urandom_range(0, 1));
    dc_rdata = 16'($urandom);
    @(negedge clk);
    check("done_req", dc_req, 0);
    check("done_stall", stall, 0);
    check("done_valid", rdata_valid, is_read && !timed_out);
    check("done_rdata", rdata, exp_rdata);
    check_err("done_err");
    next_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic apply_reset();
    quiet_inputs();
    rst = 1'b1;
    next_cycle();
    rst       = 1'b0;
    exp_rdata = 16'h0000;
    exp_err   = 1'b0;
  endtask

  task automatic reset_mid_access();
    logic [15:0] a = 16'($urandom);
    quiet_inputs();
    mem_read = 1'b1;
    addr     = a;
    next_cycle();                // detect -> BUSY 1
    next_cycle();                // BUSY 1 -> BUSY 2
    rst = 1'b1;                  // reset during BUSY 2
    next_cycle();
    rst       = 1'b0;
    mem_read  = 1'b0;
    dc_ready  = 1'b1;            // late completion must be ignored
    dc_rdata  = 16'hA5A5;
    exp_rdata = 16'h0000;
    exp_err   = 1'b0;
    @(negedge clk);
    check("rst_req", dc_req, 0);
    check("rst_we", dc_we, 0);
    check("rst_addr", dc_addr, 0);
    check("rst_wdata", dc_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_valid", rdata_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_halted", halted, 0);
    check_err("rst_err");
    next_cycle();
    @(negedge clk);
    check("rst_late_req", dc_req, 0);
    check("rst_late_valid", rdata_valid, 0);
    check("rst_late_rdata", rdata, 0);
    next_cycle();
  endtask

  task automatic halt_test();
    quiet_inputs();
    halt_in  = 1'b1;
    mem_read = 1'b1;
    @(negedge clk);
    check("halt_detect_stall", stall, 0);
    check("halt_detect_halted", halted, 0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      halt_in   = 1'($urandom_range(0, 1));
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1));
      dc_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_halted", halted, 1);
      check("halt_stall", stall, 1);
      check("halt_req", dc_req, 0);
      check("halt_valid", rdata_valid, 0);
      next_cycle();
    end
    apply_reset();
    @(negedge clk);
    check("halt_rst_halted", halted, 0);
    check("halt_rst_stall", stall, 0);
    next_cycle();
  endtask

  initial begin
    quiet_inputs();
    rst       = 1'b1;
    exp_rdata = 16'h0000;
    exp_err   = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_req", dc_req, 0);
    check("reset_we", dc_we, 0);
    check("reset_addr", dc_addr, 0);
    check("reset_wdata", dc_wdata, 0);
    check("reset_rdata", rdata, 0);
    check("reset_valid", rdata_valid, 0);
    check("reset_halted", halted, 0);
    check_err("reset_err");
    next_cycle();
    rst = 1'b0;
    idle_cycle();

    // Directed: zero-wait load, 3-wait store, then load/store back to back.
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF);
    access(1'b0, 1'b1, 16'h1234, 16'h00FF, 3, 16'h5555);
    access(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'hCAFE);
    access(1'b0, 1'b1, 16'h0102, 16'h7777, 0, 16'h0000);

`ifdef DMEM_TIMEOUT_EN
    // dc_ready on the TIMEOUT-th cycle completes normally; none at all times out.
    access(1'b1, 1'b0, 16'h0200, 16'h0000, TO - 1, 16'h1357);
    access(1'b1, 1'b0, 16'h0202, 16'h0000, 1000, 16'h2468);
    access(1'b0, 1'b1, 16'h0204, 16'h9999, 0, 16'h0000);
`endif

    // Random ops (both-high included) with random waits and gaps.
    for (int n = 0; n < 40; n++) begin
      int op = $urandom_range(0, 2);
      access(op != 1, op != 0, 16'($urandom), 16'($urandom),
             $urandom_range(0, 5), 16'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end

    reset_mid_access();
    access(1'b1, 1'b0, 16'h0ABC, 16'h0000, 2, 16'h4321);
    halt_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
